// File: rtl/uart_debug_loader.sv
// uart_debug_loader
// Command decoder sitting behind the debug UART receiver. Interprets a small
// byte protocol, assembles 32-bit instruction words (MSB first) and writes
// them into instruction memory, drives run/step control to the pipeline and
// answers every command with a one-byte ACK or NAK.
//
// Commands (decoded in IDLE):
//   'L' <count> <4*count bytes> : load words from address 0 (count 0 = 256)
//   'R' : free-run        'H' : halt
//   'S' : single step (only while halted, NAK otherwise)
//
// Ports:
//   i_clock      system clock
//   i_reset      asynchronous active-low reset
//   i_rx_data    received byte, valid with i_rx_done
//   i_rx_done    one-cycle new-byte tick
//   i_tx_done    one-cycle tick, transmitter finished the reply
//   o_tx_data    reply byte (held until i_tx_done)
//   o_tx_start   one-cycle transmit start pulse
//   o_mem_wr_en  one-cycle instruction memory write strobe
//   o_mem_addr   word address of the write
//   o_mem_data   word being written
//   o_run        processor free-running level
//   o_step       one-cycle single-step pulse
//   o_busy       high whenever not idle
module uart_debug_loader #(
  parameter int                N_BITS         = 8,
  parameter int                WORD_BITS      = 32,
  parameter int                ADDR_BITS      = 10,
  parameter int                TIMEOUT_CYCLES = 1000000,
  parameter logic [N_BITS-1:0] ACK_BYTE       = 8'hAA,
  parameter logic [N_BITS-1:0] NAK_BYTE       = 8'hEE
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [N_BITS-1:0]    i_rx_data,
  input  logic                 i_rx_done,
  input  logic                 i_tx_done,
  output logic [N_BITS-1:0]    o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_mem_wr_en,
  output logic [ADDR_BITS-1:0] o_mem_addr,
  output logic [WORD_BITS-1:0] o_mem_data,
  output logic                 o_run,
  output logic                 o_step,
  output logic                 o_busy
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam int CNT_W = N_BITS + 1;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [N_BITS-1:0] CMD_LOAD = N_BITS'(8'h4C);
  localparam logic [N_BITS-1:0] CMD_RUN  = N_BITS'(8'h52);
  localparam logic [N_BITS-1:0] CMD_HALT = N_BITS'(8'h48);
  localparam logic [N_BITS-1:0] CMD_STEP = N_BITS'(8'h53);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_COUNT, S_GET_BYTE, S_WRITE, S_SEND, S_WAIT_TX
  } state_t;

  state_t               state_q, state_d;
  logic                 run_q, run_d;
  logic                 step_q, step_d;
  logic                 wr_en_q, wr_en_d;
  logic                 tx_start_q, tx_start_d;
  logic                 busy_q, busy_d;
  logic [N_BITS-1:0]    reply_q, reply_d;
  logic [WORD_BITS-1:0] word_q, word_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           idx_q, idx_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    reply_d = reply_q;
    word_d  = word_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    step_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (i_rx_done) begin
          state_d = S_SEND;
          case (i_rx_data)
            CMD_LOAD: begin
              run_d   = 1'b0;
              state_d = S_GET_COUNT;
            end
            CMD_RUN: begin
              run_d   = 1'b1;
              reply_d = ACK_BYTE;
            end
            CMD_HALT: begin
              run_d   = 1'b0;
              reply_d = ACK_BYTE;
            end
            CMD_STEP: begin
              // Stepping a free-running core is refused.
              if (run_q) begin
                reply_d = NAK_BYTE;
              end else begin
                step_d  = 1'b1;
                reply_d = ACK_BYTE;
              end
            end
            default: reply_d = NAK_BYTE;
          endcase
        end
      end

      S_GET_COUNT: begin
        // A byte arriving on the expiry cycle takes priority over the abort.
        if (i_rx_done) begin
          cnt_d   = (i_rx_data == '0) ? {1'b1, {N_BITS{1'b0}}} : {1'b0, i_rx_data};
          addr_d  = '0;
          idx_d   = '0;
          tmo_d   = '0;
          state_d = S_GET_BYTE;
        end else if (tmo_q == TMO_LAST) begin
          reply_d = NAK_BYTE;
          state_d = S_SEND;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_GET_BYTE: begin
        if (i_rx_done) begin
          word_d = {word_q[WORD_BITS-N_BITS-1:0], i_rx_data};
          tmo_d  = '0;
          if (idx_q == 2'd3) begin
            idx_d   = '0;
            state_d = S_WRITE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Words already written stay in memory.
          reply_d = NAK_BYTE;
          state_d = S_SEND;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_WRITE: begin
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          reply_d = ACK_BYTE;
          state_d = S_SEND;
        end else begin
          state_d = S_GET_BYTE;
        end
      end

      S_SEND: state_d = S_WAIT_TX;

      // Received bytes are ignored here and in SEND.
      S_WAIT_TX: if (i_tx_done) state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so each pulse lines up
    // with the cycle its state is occupied.
    wr_en_d    = (state_d == S_WRITE);
    tx_start_d = (state_d == S_SEND);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      run_q      <= 1'b0;
      step_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      reply_q    <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      step_q     <= step_d;
      wr_en_q    <= wr_en_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      reply_q    <= reply_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
    end
  end

  assign o_tx_data   = reply_q;
  assign o_tx_start  = tx_start_q;
  assign o_mem_wr_en = wr_en_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_data  = word_q;
  assign o_run       = run_q;
  assign o_step      = step_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_debug_loader.sv
// Testbench for uart_debug_loader: randomized command stream against a
// protocol-level reference model, with a scoreboard monitor that checks
// memory writes, step pulses and reply bytes as the DUT produces them.
module tb_uart_debug_loader;

  localparam int TMO   = 100;
  localparam int ABITS = 8;
  localparam logic [7:0] ACK = 8'hAA;
  localparam logic [7:0] NAK = 8'hEE;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       rx_data = '0;
  logic             rx_done = 1'b0;
  logic             tx_done = 1'b0;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             mem_wr_en;
  logic [ABITS-1:0] mem_addr;
  logic [31:0]      mem_data;
  logic             run;
  logic             step;
  logic             busy;

  uart_debug_loader #(
    .N_BITS(8), .WORD_BITS(32), .ADDR_BITS(ABITS), .TIMEOUT_CYCLES(TMO),
    .ACK_BYTE(ACK), .NAK_BYTE(NAK)
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_tx_done(tx_done), .o_tx_data(tx_data), .o_tx_start(tx_start),
    .o_mem_wr_en(mem_wr_en), .o_mem_addr(mem_addr), .o_mem_data(mem_data),
    .o_run(run), .o_step(step), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [ABITS-1:0] addr; logic [31:0] data; int cyc; } wr_t;
  typedef struct { logic [7:0] b; logic run; } rp_t;
  wr_t wr_q[$];
  rp_t rp_q[$];
  int  step_q[$];
  logic [31:0] load_words[$];

  int   n_pass = 0;
  int   n_total = 0;
  int   last_tick = 0;
  logic model_run = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_event(input string name, input logic [31:0] act);
    n_total++;
    $display("FAIL %s: got %h expected no event (cycle %0d)", name, act, cyc);
  endtask

  // Scoreboard monitor
  initial begin
    wr_t w;
    rp_t r;
    int  s;
    forever begin
      @(negedge clk);
      if (mem_wr_en) begin
        if (step) fail_event("step_with_write", {31'b0, step});
        if (wr_q.size() == 0) fail_event("unexpected_write", {24'b0, mem_addr});
        else begin
          w = wr_q.pop_front();
          check("wr_addr", {24'b0, mem_addr}, {24'b0, w.addr});
          check("wr_data", mem_data, w.data);
          check("wr_cycle", cyc, w.cyc);
        end
      end
      if (step) begin
        if (step_q.size() == 0) fail_event("unexpected_step", {31'b0, step});
        else begin
          s = step_q.pop_front();
          check("step_cycle", cyc, s);
        end
      end
      if (tx_start) begin
        if (rp_q.size() == 0) fail_event("unexpected_reply", {24'b0, tx_data});
        else begin
          r = rp_q.pop_front();
          check("reply_byte", {24'b0, tx_data}, {24'b0, r.b});
          check("run_at_reply", {31'b0, run}, {31'b0, r.run});
        end
      end
    end
  end

  // Transmitter model: finishes each reply after a random delay.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Raise a one-cycle rx tick 'gap' cycles from now (called at posedge+1).
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap - 1) @(posedge clk);
    #1;
    rx_data   = b;
    rx_done   = 1'b1;
    last_tick = cyc;
    @(posedge clk);
    #1 rx_done = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
    end
    check("idle_reached", {31'b0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Single-byte commands, expectation derived from the protocol rules.
  task automatic cmd_simple(input logic [7:0] b);
    logic want_step = 1'b0;
    case (b)
      8'h52: begin model_run = 1'b1; rp_q.push_back('{ACK, 1'b1}); end
      8'h48: begin model_run = 1'b0; rp_q.push_back('{ACK, 1'b0}); end
      8'h53: begin
        if (model_run) rp_q.push_back('{NAK, 1'b1});
        else begin rp_q.push_back('{ACK, 1'b0}); want_step = 1'b1; end
      end
      default: rp_q.push_back('{NAK, model_run});
    endcase
    send_byte(b, 2);
    if (want_step) step_q.push_back(last_tick + 1);
    if (b == 8'h52) check("run_after_R", {31'b0, run}, 32'd1);
    wait_idle(200);
  endtask

  // Load every word in load_words starting at address 0.
  task automatic cmd_load(input int gap_lo, input int gap_hi);
    int n = load_words.size();
    model_run = 1'b0;
    rp_q.push_back('{ACK, 1'b0});
    send_byte(8'h4C, 2);
    send_byte(8'(n % 256), $urandom_range(gap_lo, gap_hi));
    for (int i = 0; i < n; i++) begin
      for (int k = 3; k >= 0; k--)
        send_byte(8'(load_words[i] >> (8 * k)), $urandom_range(gap_lo, gap_hi));
      wr_q.push_back('{ABITS'(i % 256), load_words[i], last_tick + 1});
    end
    wait_idle(300);
  endtask

  initial begin
    logic [7:0] b;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_run", {31'b0, run}, 0);
    check("rst_addr_data", mem_data | {24'b0, mem_addr}, 0);
    check("rst_strobes", {29'b0, tx_start, mem_wr_en, step}, 0);
    check("rst_tx_data", {24'b0, tx_data}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    cmd_simple(8'h52);

    load_words = '{32'h12345678, 32'h9ABCDEF0};
    cmd_load(2, 4);
    check("run_after_load", {31'b0, run}, 0);

    cmd_simple(8'h53);
    cmd_simple(8'h52);
    cmd_simple(8'h53);
    cmd_simple(8'h48);

    // Timeout abort: one byte of the word then silence.
    rp_q.push_back('{NAK, 1'b0});
    model_run = 1'b0;
    send_byte(8'h4C, 2);
    send_byte(8'h01, 3);
    send_byte(8'h11, 3);
    wait_idle(400);

    // A byte on the expiry cycle is still accepted.
    rp_q.push_back('{ACK, 1'b0});
    send_byte(8'h4C, 2);
    send_byte(8'h01, 3);
    send_byte(8'h11, 3);
    send_byte(8'h22, TMO);
    send_byte(8'h33, 3);
    send_byte(8'h44, 3);
    wr_q.push_back('{ABITS'(0), 32'h11223344, last_tick + 1});
    wait_idle(200);

    // One cycle later is too late: aborted, and the late byte is dropped.
    rp_q.push_back('{NAK, 1'b0});
    send_byte(8'h4C, 2);
    send_byte(8'h01, 3);
    send_byte(8'h11, 3);
    send_byte(8'h22, TMO + 1);
    wait_idle(200);

    // Count 0 means 256 words; addresses cover the full 8-bit space.
    load_words.delete();
    for (int i = 0; i < 256; i++) load_words.push_back($urandom);
    cmd_load(2, 4);

    // Randomized command mix against the model.
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 4))
        0: cmd_simple(8'h52);
        1: cmd_simple(8'h48);
        2: cmd_simple(8'h53);
        3: begin
          load_words.delete();
          repeat ($urandom_range(1, 3)) load_words.push_back($urandom);
          cmd_load(2, 6);
        end
        default: begin
          do b = 8'($urandom_range(0, 255));
          while (b == 8'h4C || b == 8'h52 || b == 8'h48 || b == 8'h53);
          cmd_simple(b);
        end
      endcase
    end

    // Asynchronous reset in the middle of a word: no write, no reply.
    cmd_simple(8'h52);
    send_byte(8'h4C, 2);
    send_byte(8'h02, 3);
    send_byte(8'h12, 3);
    send_byte(8'h34, 3);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 0);
    check("mid_rst_data", mem_data, 0);
    check("mid_rst_strobes", {28'b0, run, tx_start, mem_wr_en, step}, 0);
    model_run = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("post_rst_busy", {31'b0, busy}, 0);

    check("writes_left", wr_q.size(), 0);
    check("replies_left", rp_q.size(), 0);
    check("steps_left", step_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
